// File: rtl/key_conditioner.sv
// Debounces four active-low board buttons into registered held levels and one-cycle press pulses.
// Define KEY_AUTOREPEAT_EN to add auto-repeat pulses while a key stays pressed.
module key_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 7500000
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic [3:0] KEY,
   output logic [3:0] press_pulse,
   output logic [3:0] held
);

   localparam int CNT_MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
   localparam int CNT_MAX    = (CNT_MAX_AB > REPEAT_PERIOD) ? CNT_MAX_AB : REPEAT_PERIOD;
   localparam int CW         = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] CNT_SAT = CW'(CNT_MAX);
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
`ifdef KEY_AUTOREPEAT_EN
   localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);
`endif

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } key_state_t;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
      return (x == CNT_SAT) ? x : x + CNT_ONE;
   endfunction

   // Observable per-key FSM state for checkers.
   key_state_t key_state [4];

   for (genvar k = 0; k < 4; k++) begin : g_key
      logic          sync1, sync2;
      key_state_t    state, state_nx;
      logic [CW-1:0] cnt, cnt_nx;
      logic          fire, fire_q;
      logic          held_q, pulse_q;
`ifdef KEY_AUTOREPEAT_EN
      logic [CW-1:0] rcnt, rcnt_nx;
      logic          rfirst, rfirst_nx;
`endif

      // The fire flag is staged once more so outputs come from settled FSM state.
      always_ff @(posedge clock or negedge resetn) begin
         if (!resetn) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            state   <= RELEASED;
            cnt     <= '0;
            fire_q  <= 1'b0;
            pulse_q <= 1'b0;
            held_q  <= 1'b0;
         end else begin
            sync1   <= ~KEY[k];
            sync2   <= sync1;
            state   <= state_nx;
            cnt     <= cnt_nx;
            fire_q  <= fire;
            pulse_q <= fire_q;
            held_q  <= (state == PRESSED) || (state == RELEASE_WAIT);
         end
      end

`ifdef KEY_AUTOREPEAT_EN
      always_ff @(posedge clock or negedge resetn) begin
         if (!resetn) begin
            rcnt   <= '0;
            rfirst <= 1'b1;
         end else begin
            rcnt   <= rcnt_nx;
            rfirst <= rfirst_nx;
         end
      end
`endif

      always_comb begin
         state_nx = state;
         cnt_nx   = cnt;
         fire     = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
         rcnt_nx   = rcnt;
         rfirst_nx = rfirst;
`endif
         case (state)
            RELEASED: begin
               if (sync2) begin
                  state_nx = PRESS_WAIT;
                  cnt_nx   = '0;
               end
            end
            PRESS_WAIT: begin
               if (!sync2) begin
                  state_nx = RELEASED;
                  cnt_nx   = '0;
               end else if (cnt == DB_LAST) begin
                  state_nx = PRESSED;
                  cnt_nx   = '0;
                  fire     = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                  rcnt_nx   = '0;
                  rfirst_nx = 1'b1;
`endif
               end else begin
                  cnt_nx = sat_inc(cnt);
               end
            end
            PRESSED: begin
               if (!sync2) begin
                  state_nx = RELEASE_WAIT;
                  cnt_nx   = '0;
`ifdef KEY_AUTOREPEAT_EN
                  rcnt_nx   = '0;
                  rfirst_nx = 1'b1;
               end else if (rcnt == (rfirst ? RD_LAST : RP_LAST)) begin
                  // First repeat waits the long delay, later ones the period.
                  fire      = 1'b1;
                  rcnt_nx   = '0;
                  rfirst_nx = 1'b0;
               end else begin
                  rcnt_nx = sat_inc(rcnt);
`endif
               end
            end
            RELEASE_WAIT: begin
               if (sync2) begin
                  state_nx = PRESSED;
                  cnt_nx   = '0;
`ifdef KEY_AUTOREPEAT_EN
                  rcnt_nx   = '0;
                  rfirst_nx = 1'b1;
`endif
               end else if (cnt == DB_LAST) begin
                  state_nx = RELEASED;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = sat_inc(cnt);
               end
            end
            default: begin
               state_nx = RELEASED;
               cnt_nx   = '0;
            end
         endcase
      end

      assign press_pulse[k] = pulse_q;
      assign held[k]        = held_q;
      assign key_state[k]   = state;
   end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: run-length behavioural model with a per-cycle compare,
// plus directed scenarios pinned by literal expectations.
module tb_key_conditioner;

   localparam int D  = 4;
   localparam int RD = 20;
   localparam int RP = 8;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic [3:0] key_drv = 4'hF;
   logic [3:0] press_pulse;
   logic [3:0] held;

   int checks = 0;
   int errors = 0;

   key_conditioner #(
      .DEBOUNCE_CYCLES(D),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP)
   ) dut (
      .clock      (clock),
      .resetn     (resetn),
      .KEY        (key_drv),
      .press_pulse(press_pulse),
      .held       (held)
   );

   // clock / reset
   always #5 clock = ~clock;

   // ---------------- behavioural model / scoreboard ----------------
   // A key's debounced level flips once its raw level has been stable for D+1
   // samples; outputs show that decision three edges after the deciding sample.
   logic [7:0] exp_q[$];
   logic [7:0] exp_now;
   int         run_len [4];
   logic       run_lvl [4];
   logic       down    [4];
   logic       prs     [4];
   int         t_in    [4];

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin
         run_len[k] = 0;
         run_lvl[k] = 1'b0;
         down[k]    = 1'b0;
         prs[k]     = 1'b0;
         t_in[k]    = 0;
      end
      exp_q.delete();
      for (int i = 0; i < 3; i++) exp_q.push_back(8'h00);
      exp_now = 8'h00;
   endtask

   task automatic model_step();
      logic [7:0] r;
      logic       b, f, now_p;
      r = 8'h00;
      for (int k = 0; k < 4; k++) begin
         b = ~key_drv[k];
         if (b == run_lvl[k]) begin
            if (run_len[k] < 1000) run_len[k]++;
         end else begin
            run_lvl[k] = b;
            run_len[k] = 1;
         end
         f = 1'b0;
         if (!down[k] && b && run_len[k] == D + 1) begin
            down[k] = 1'b1;
            f = 1'b1;
         end else if (down[k] && !b && run_len[k] == D + 1) begin
            down[k] = 1'b0;
         end
         now_p = down[k] && b;
`ifdef KEY_AUTOREPEAT_EN
         if (now_p) begin
            t_in[k] = prs[k] ? t_in[k] + 1 : 0;
            if (t_in[k] == RD || (t_in[k] > RD && (t_in[k] - RD) % RP == 0)) f = 1'b1;
         end
`endif
         prs[k]   = now_p;
         r[k]     = f;
         r[4 + k] = down[k];
      end
      exp_q.push_back(r);
      exp_now = exp_q.pop_front();
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clock);
         if (!resetn) model_reset();
         else model_step();
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // compare process: every cycle, away from the active edge
   initial begin
      forever begin
         @(posedge clock);
         #1;
         chk("model_pulse", {4'h0, press_pulse}, {4'h0, exp_now[3:0]});
         chk("model_held", {4'h0, held}, {4'h0, exp_now[7:4]});
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic settle(input int n);
      key_drv = 4'hF;
      repeat (n) tick();
   endtask

   function automatic logic in_list(input int e, input bit rep);
      if (e == 7) return 1'b1;
      if (!rep) return 1'b0;
      return (e == 27 || e == 35 || e == 43 || e == 51 || e == 59);
   endfunction

   // ---------------- directed scenarios ----------------
   initial begin
      bit rep;
`ifdef KEY_AUTOREPEAT_EN
      rep = 1'b1;
`else
      rep = 1'b0;
`endif
      resetn  = 1'b0;
      key_drv = 4'hF;
      repeat (3) tick();
      chk("reset_pulse", {4'h0, press_pulse}, 8'h00);
      chk("reset_held", {4'h0, held}, 8'h00);
      resetn = 1'b1;
      settle(5);

      // single press on KEY[1]
      key_drv = 4'b1101;
      for (int e = 0; e < 12; e++) begin
         tick();
         chk("press_pulse_k1", {4'h0, press_pulse}, (e == 7) ? 8'h02 : 8'h00);
         chk("press_held_k1", {7'h0, held[1]}, (e >= 7) ? 8'h01 : 8'h00);
      end
      settle(14);

      // bounce on KEY[3] is rejected
      for (int e = 0; e < 15; e++) begin
         key_drv = (e == 0 || e == 1 || e == 3 || e == 4) ? 4'b0111 : 4'hF;
         tick();
         chk("bounce_pulse", {4'h0, press_pulse}, 8'h00);
         chk("bounce_held", {4'h0, held}, 8'h00);
      end
      settle(4);

      // simultaneous KEY[3] and KEY[2]
      key_drv = 4'b0011;
      for (int e = 0; e < 12; e++) begin
         tick();
         chk("simul_pulse", {4'h0, press_pulse}, (e == 7) ? 8'h0C : 8'h00);
      end
      settle(14);

      // long hold on KEY[0]
      key_drv = 4'b1110;
      for (int e = 0; e < 70; e++) begin
         if (e == 60) key_drv = 4'hF;
         tick();
         chk("hold_pulse_k0", {4'h0, press_pulse}, in_list(e, rep) ? 8'h01 : 8'h00);
      end
      settle(14);

      // reset mid-debounce with KEY[1] held across it
      key_drv = 4'b1101;
      repeat (5) tick();
      resetn = 1'b0;
      #1;
      chk("async_reset_pulse", {4'h0, press_pulse}, 8'h00);
      chk("async_reset_held", {4'h0, held}, 8'h00);
      for (int e = 0; e < 3; e++) begin
         tick();
         chk("in_reset_pulse", {4'h0, press_pulse}, 8'h00);
         chk("in_reset_held", {4'h0, held}, 8'h00);
      end
      resetn = 1'b1;
      for (int e = 0; e < 12; e++) begin
         tick();
         chk("post_reset_pulse", {4'h0, press_pulse}, (e == 7) ? 8'h02 : 8'h00);
      end
      settle(14);

      // release glitch on KEY[1] during release debounce
      for (int e = 0; e < 32; e++) begin
         key_drv = (e <= 15 || e == 18) ? 4'b1101 : 4'hF;
         tick();
         chk("glitch_held_k1", {7'h0, held[1]}, (e >= 7 && e <= 25) ? 8'h01 : 8'h00);
         chk("glitch_pulse", {4'h0, press_pulse}, (e == 7) ? 8'h02 : 8'h00);
      end
      settle(4);

      // staggered presses on KEY[3] and KEY[0], model-checked
      for (int e = 0; e < 40; e++) begin
         if (e < 2) key_drv = 4'b0111;
         else if (e < 20) key_drv = 4'b0110;
         else if (e < 23) key_drv = 4'b1110;
         else key_drv = 4'hF;
         tick();
      end
      settle(14);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
